// File: rtl/fn_sw_sched.sv
// Round-robin scheduler that streams WIDTH-bit operands LSB-first through one shared 1-bit logic unit.
// Latency: gnt one cycle after the grant edge and done/result WIDTH cycles later. Losing requesters keep req asserted until granted.
module fn_sw_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ*2-1:0]     op_sel,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  fn_a,
  output logic                  fn_b,
  output logic [1:0]            fn_sel,
  input  logic                  fn_y
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    ptr, owner, win;
  logic             found;
  logic             last;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
  logic [1:0]       sel_reg;
  int               idx;

  assign last = (cnt == CW'(WIDTH - 1));

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    res_nxt      = res_reg;
    res_nxt[cnt] = fn_y;
    fn_a         = 1'b0;
    fn_b         = 1'b0;
    fn_sel       = 2'b00;
    case (state)
      IDLE: if (found) state_nxt = RUN;
      RUN: begin
        fn_a   = a_reg[cnt];
        fn_b   = b_reg[cnt];
        fn_sel = sel_reg;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      owner   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sel_reg <= '0;
      res_reg <= '0;
      result  <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      gnt   <= '0;
      done  <= '0;
      case (state)
        IDLE: if (found) begin
          a_reg   <= op_a[int'(win)*WIDTH +: WIDTH];
          b_reg   <= op_b[int'(win)*WIDTH +: WIDTH];
          sel_reg <= op_sel[int'(win)*2 +: 2];
          owner   <= win;
          gnt     <= NREQ'(1) << win;
          cnt     <= '0;
          ptr     <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
        RUN: begin
          res_reg <= res_nxt;
          if (last) begin
            // res_nxt already carries the final bit from this cycle.
            result <= res_nxt;
            done   <= NREQ'(1) << owner;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fn_sw_sched.sv
// Directed bench for fn_sw_sched with the shared 1-bit logic unit modelled inline.
module tb_fn_sw_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] op_a = '0;
  logic [NREQ*WIDTH-1:0] op_b = '0;
  logic [NREQ*2-1:0]     op_sel = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  busy, fn_a, fn_b, fn_y;
  logic [WIDTH-1:0]      result;
  logic [1:0]            fn_sel;

  int n_cmp = 0;
  int n_bad = 0;

  fn_sw_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt), .busy(busy), .done(done), .result(result),
    .fn_a(fn_a), .fn_b(fn_b), .fn_sel(fn_sel), .fn_y(fn_y)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (fn_sel)
      2'b00:   fn_y = fn_a & fn_b;
      2'b01:   fn_y = fn_a | fn_b;
      2'b10:   fn_y = fn_a ^ fn_b;
      default: fn_y = ~(fn_a ^ fn_b);
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_slot(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    op_a[id*WIDTH +: WIDTH] = a;
    op_b[id*WIDTH +: WIDTH] = b;
    op_sel[id*2 +: 2]       = s;
  endtask

  // Called at a negedge where the scheduler is IDLE; req is applied at once.
  task automatic run_op(input string nm, input logic [3:0] rq, input logic [3:0] eg,
                        input logic [7:0] ea, input logic [1:0] es, input logic [7:0] er,
                        input bit hold);
    logic [7:0] fa;
    int n;
    bit got;
    fa = '0;
    req = rq;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_fnsel"}, 32'(fn_sel), 32'(es));
    fa[0] = fn_a;
    if (!hold) begin
      req    = '0;
      op_a   = ~op_a;
      op_b   = ~op_b;
      op_sel = ~op_sel;
    end
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (done != '0) got = 1'b1;
      else if (n < 8) fa[n] = fn_a;
    end
    chk({nm, "_latency"}, 32'(n), 32'd8);
    chk({nm, "_done"}, 32'(done), 32'(eg));
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_fna_bits"}, 32'(fa), 32'(ea));
    chk({nm, "_idle_sel"}, 32'({busy, fn_sel}), 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [7:0] a, b;
    logic [1:0] sel;
    logic [3:0] eg;
    logic [7:0] er;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{0, 8'hF0, 8'hCC, 2'b00, 4'b0001, 8'hC0};
    tbl[1] = '{0, 8'hF0, 8'hCC, 2'b01, 4'b0001, 8'hFC};
    tbl[2] = '{0, 8'hF0, 8'hCC, 2'b10, 4'b0001, 8'h3C};
    tbl[3] = '{0, 8'hF0, 8'hCC, 2'b11, 4'b0001, 8'hC3};
    tbl[4] = '{1, 8'hFF, 8'h01, 2'b00, 4'b0010, 8'h01};
    tbl[5] = '{2, 8'hA5, 8'h0F, 2'b10, 4'b0100, 8'hAA};
    tbl[6] = '{3, 8'h12, 8'h34, 2'b01, 4'b1000, 8'h36};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outputs", 32'({gnt, done, busy, result, fn_a, fn_b, fn_sel}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_no_gnt", 32'(gnt), 32'd0);
      chk("idle_no_done", 32'(done), 32'd0);
    end

    // Single-requester operations; operands scrambled after each grant
    for (int i = 0; i < 7; i++) begin
      set_slot(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sel);
      run_op($sformatf("vec%0d", i), 4'(1 << tbl[i].id), tbl[i].eg, tbl[i].a, tbl[i].sel, tbl[i].er, 1'b0);
    end

    // Contention with req held: pointer is 0 after the grant to requester 3
    set_slot(0, 8'h0F, 8'h33, 2'b00);
    set_slot(1, 8'h0F, 8'h33, 2'b01);
    set_slot(2, 8'h0F, 8'h33, 2'b10);
    set_slot(3, 8'h0F, 8'h33, 2'b11);
    run_op("cont0", 4'b1111, 4'b0001, 8'h0F, 2'b00, 8'h03, 1'b1);
    run_op("cont1", 4'b1111, 4'b0010, 8'h0F, 2'b01, 8'h3F, 1'b1);
    run_op("cont2", 4'b1111, 4'b0100, 8'h0F, 2'b10, 8'h3C, 1'b1);
    run_op("cont3", 4'b1111, 4'b1000, 8'h0F, 2'b11, 8'hC3, 1'b1);
    run_op("cont4", 4'b1111, 4'b0001, 8'h0F, 2'b00, 8'h03, 1'b0);

    // Pointer wrap
    set_slot(2, 8'hA5, 8'h0F, 2'b10);
    run_op("ptr_g2", 4'b0100, 4'b0100, 8'hA5, 2'b10, 8'hAA, 1'b0);
    set_slot(0, 8'hF0, 8'hCC, 2'b00);
    set_slot(2, 8'hA5, 8'h0F, 2'b10);
    run_op("ptr_wrap", 4'b0101, 4'b0001, 8'hF0, 2'b00, 8'hC0, 1'b0);
    set_slot(0, 8'hF0, 8'hCC, 2'b00);
    set_slot(2, 8'hA5, 8'h0F, 2'b10);
    run_op("ptr_next", 4'b0101, 4'b0100, 8'hA5, 2'b10, 8'hAA, 1'b0);

    // Abort mid-run: pointer was 3, reset must bring it back to 0
    set_slot(2, 8'h55, 8'hFF, 2'b00);
    req = 4'b0100;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'b0100);
    req = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outs", 32'({gnt, done, result, fn_sel}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    set_slot(1, 8'h3C, 8'h5A, 2'b10);
    set_slot(3, 8'h11, 8'h22, 2'b01);
    run_op("post_abort", 4'b1010, 4'b0010, 8'h3C, 2'b10, 8'h66, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
